// File: rtl/mat_mul_seq_ctrl_if.sv
// Datapath issue/result and result-stream handshake bundle for mat_mul_seq_ctrl.
// WORD_LEN defaults to 16 when not supplied by the build.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

interface mat_mul_seq_ctrl_if #(
  parameter int IDX_W = 2
);
  logic                        dp_issue;
  logic [IDX_W-1:0]            dp_row;
  logic [IDX_W-1:0]            dp_col;
  logic signed [`WORD_LEN-1:0] dp_result;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [`WORD_LEN-1:0] res_data;
  logic [IDX_W-1:0]            res_row;
  logic [IDX_W-1:0]            res_col;

  modport master (
    output dp_issue, dp_row, dp_col,
    input  dp_result,
    output res_valid, res_data, res_row, res_col,
    input  res_ready
  );

  modport slave (
    input  dp_issue, dp_row, dp_col,
    output dp_result,
    input  res_valid, res_data, res_row, res_col,
    output res_ready
  );
endinterface

// File: rtl/mat_mul_seq_ctrl.sv
// Sequences an N x N product through a fixed-latency dot-product datapath, collecting
// results in a credit-protected FIFO. Define MATMUL_PERF_EN for perf_cycles/perf_stall.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

module mat_mul_seq_ctrl #(
  parameter int N          = 4,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  mat_mul_seq_ctrl_if.master bus
`ifdef MATMUL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic signed [`WORD_LEN-1:0] data;
    logic [IDX_W-1:0]            row;
    logic [IDX_W-1:0]            col;
  } res_t;

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              row, col;
  logic [PIPE_LAT:1]             vld_pipe;
  logic [PIPE_LAT:1][IDX_W-1:0]  row_pipe, col_pipe;
  logic [CNT_W-1:0]              inflight, fifo_cnt;
  logic [CNT_W:0]                occ;
  res_t [FIFO_DEPTH-1:0]         mem;
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic                          issue, push, pop, last_idx, accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit is taken from registered occupancy only, so a same-cycle pop never
  // lets an extra element in; this is what keeps the FIFO from overflowing.
  assign occ      = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign issue    = (state == S_ISSUE) && (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign last_idx = (row == LAST) && (col == LAST);
  assign accept   = (state == S_IDLE) && start;
  assign push     = vld_pipe[PIPE_LAT];
  assign pop      = bus.res_valid && bus.res_ready;

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.dp_issue  = issue;
  assign bus.dp_row    = row;
  assign bus.dp_col    = col;
  assign bus.res_valid = (fifo_cnt != '0);
  assign bus.res_data  = mem[rd_ptr].data;
  assign bus.res_row   = mem[rd_ptr].row;
  assign bus.res_col   = mem[rd_ptr].col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (issue && last_idx) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight == '0 && fifo_cnt == '0 && !pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row-major walk; the final wrap leaves the indices at (0,0) for the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      row <= '0;
      col <= '0;
    end else if (issue) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      row_pipe <= '0;
      col_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      row_pipe[1] <= row;
      col_pipe[1] <= col;
      for (int s = 2; s <= PIPE_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        row_pipe[s] <= row_pipe[s-1];
        col_pipe[s] <= col_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: bus.dp_result, row: row_pipe[PIPE_LAT], col: col_pipe[PIPE_LAT]};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef MATMUL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state == S_ISSUE && !issue && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
